lane_alu_pipe: RTL
==================

Name: lane_alu_pipe

Overview:
Parametrised multi-lane arithmetic engine with runtime per-lane opcode, optional saturation, and a 2-stage stallable valid/ready pipeline. Stage 1 registers the per-lane results and flags. Stage 2 registers the results plus a cross-lane reduction sum. It sits between a flattened-vector producer and consumer in the datapath. It replaces fixed add/sub lane arrays whose operation is fixed by lane index at elaboration.

Parameters:
NUM_LANES, 4, number of parallel lanes (>=1)
DATA_WIDTH, 8, bits per lane
SATURATE, 0, 1 = ADD clamps to all-ones and SUB clamps to 0 on overflow/underflow
COUNT_WIDTH, 16, width of the output-beat counter

Ports:
clk  input  1  clock
rst_n  input  1  reset
in_valid  input  1  input beat valid
in_ready  output  1  input beat accepted when in_valid && in_ready
data_in  input  NUM_LANES*DATA_WIDTH  operand A; lane i = [i*DATA_WIDTH +: DATA_WIDTH]
operand  input  NUM_LANES*DATA_WIDTH  operand B, same packing as data_in
op  input  NUM_LANES*2  per-lane opcode, lane i = [2*i +: 2]
out_valid  output  1  output beat valid
out_ready  input  1  downstream accept
result  output  NUM_LANES*DATA_WIDTH  per-lane results, same packing as data_in
flags  output  NUM_LANES  per-lane carry/borrow/compare flag
sum_out  output  DATA_WIDTH+$clog2(NUM_LANES)+1  unsigned sum of all lane results of the same beat
beat_count  output  COUNT_WIDTH  number of completed output handshakes

Behaviour:
- One clock (clk). Reset rst_n is asynchronous, active-low.
- Reset: in_ready=1 on the first cycle after release. out_valid, result, flags, sum_out, beat_count and all internal valids = 0.
- Opcodes, all unsigned:
  - 00 ADD: a+b; flag = carry out.
  - 01 SUB: a-b; flag = borrow (a<b).
  - 10 PASS: a; flag = 0.
  - 11 ABSDIFF: |a-b|; flag = (a<b).
- SATURATE=1 affects ADD and SUB only. ADD with carry gives all-ones; SUB with borrow gives 0. Flags are unchanged. SATURATE=0 wraps modulo 2^DATA_WIDTH.
- Pipeline:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no skid buffer).
- Stage 1 captures lane results and flags on input handshake. Stage 1 valid clears when s1_adv is true and there is no input handshake.
- Stage 2 captures stage-1 data plus sum_out when s1_valid && s2_adv.
- Latency: accepted at edge N, visible on outputs after edge N+2 with no stall. Throughput is 1 beat/cycle.
- Registered outputs hold stable while out_valid && !out_ready.
- Order preserved. No drop or duplication under any out_ready pattern.
- Simultaneous stage-2 output and new stage-1 capture in one cycle is legal; stage 2 takes the new beat.
- beat_count increments on out_valid && out_ready and wraps to 0 at 2^COUNT_WIDTH.
- Reset asserted mid-stream: all in-flight beats are discarded and all outputs go to reset values immediately.
- sum_out width guarantees no overflow (NUM_LANES=1 gives DATA_WIDTH+1 bits).

Decomposition:
- Package lane_alu_pkg: op_e enum (OP_ADD=2'b00, OP_SUB, OP_PASS, OP_ABSDIFF) and the OP_WIDTH=2 constant.
- Sub-module lane_alu_unit: combinational single-lane op, saturate and flag logic, parametrised on DATA_WIDTH and SATURATE. It is instantiated NUM_LANES times in a generate loop in lane_alu_pipe.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> out_valid=0, result=0, sum_out=0, beat_count=0. in_ready=1 on the first cycle after release.
- Mixed ops (defaults, SATURATE=0):
  - Stimulus: A lanes {0x10,0x30,0xF0,0x05}, B lanes {0x05,0x10,0x20,0x09}, ops {ADD,SUB,ADD,ABSDIFF}.
  - Response two cycles later: result {0x15,0x20,0x10,0x04}, flags 4'b1100 (lane3..0), sum_out=0x49.
- Saturation (SATURATE=1):
  - Stimulus: lane0 ADD 0xF0+0x20; lane1 SUB 0x05-0x09.
  - Response: lane0 = 0xFF, flag=1; lane1 = 0x00, flag=1.
- Backpressure:
  - Stimulus: stream 6 beats with out_ready=0 for 5 cycles, then 1.
  - Response: in_ready drops after 2 beats are accepted. All 6 beats emerge in order with no loss or duplication. Outputs stay stable while stalled. beat_count=6.
- Reset mid-stream: assert rst_n=0 with 2 beats in flight -> out_valid falls immediately. No stale beat appears after release.
- Counter wrap (COUNT_WIDTH=4): 17 output handshakes -> beat_count=1.

Source files
------------

// File: rtl/lane_alu_pkg.sv
// lane_alu_pkg: opcode encoding shared by the lane ALU pipeline and its lanes.
package lane_alu_pkg;
    localparam int OP_WIDTH = 2;
    typedef enum logic [OP_WIDTH-1:0] {
        OP_ADD     = 2'b00,
        OP_SUB     = 2'b01,
        OP_PASS    = 2'b10,
        OP_ABSDIFF = 2'b11
    } op_e;
endpackage

// File: rtl/lane_alu_unit.sv
// lane_alu_unit: combinational single-lane unsigned op with optional saturation and flag.
module lane_alu_unit
    import lane_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SATURATE   = 0
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [OP_WIDTH-1:0]   op,
    output logic [DATA_WIDTH-1:0] y,
    output logic                  flag
);
    logic [DATA_WIDTH:0] sum;
    logic [DATA_WIDTH:0] diff;
    logic                carry;
    logic                borrow;
    logic                sat;
    assign sum    = {1'b0, a} + {1'b0, b};
    assign diff   = {1'b0, a} - {1'b0, b};
    assign carry  = sum[DATA_WIDTH];
    assign borrow = diff[DATA_WIDTH];
    assign sat    = SATURATE != 0;
    assign flag   = (op == OP_ADD) ? carry : (op == OP_PASS) ? 1'b0 : borrow;
    always_comb begin
        y = a;
        if (op == OP_ADD)
            y = (sat && carry) ? {DATA_WIDTH{1'b1}} : sum[DATA_WIDTH-1:0];
        else if (op == OP_SUB)
            y = (sat && borrow) ? '0 : diff[DATA_WIDTH-1:0];
        else if (op == OP_ABSDIFF)
            y = borrow ? b - a : diff[DATA_WIDTH-1:0];
    end
endmodule

// File: rtl/lane_alu_pipe.sv
// lane_alu_pipe: multi-lane runtime-opcode ALU behind a 2-stage stallable valid/ready pipeline,
// with a cross-lane sum added in stage 2 and a completed-beat counter.
module lane_alu_pipe
    import lane_alu_pkg::*;
#(
    parameter int NUM_LANES   = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int SATURATE    = 0,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]              data_in,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]              operand,
    input  logic [NUM_LANES*OP_WIDTH-1:0]                op,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [NUM_LANES*DATA_WIDTH-1:0]              result,
    output logic [NUM_LANES-1:0]                         flags,
    output logic [DATA_WIDTH+$clog2(NUM_LANES):0]        sum_out,
    output logic [COUNT_WIDTH-1:0]                       beat_count
);
    localparam int SUM_W = DATA_WIDTH + $clog2(NUM_LANES) + 1;
    logic [NUM_LANES*DATA_WIDTH-1:0] lane_res;
    logic [NUM_LANES-1:0]            lane_flag;
    logic                            s1_valid;
    logic [NUM_LANES*DATA_WIDTH-1:0] s1_res;
    logic [NUM_LANES-1:0]            s1_flags;
    logic [SUM_W-1:0]                s1_sum;
    logic                            s1_adv;
    logic                            s2_adv;
    logic                            in_hs;
    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_lane
            lane_alu_unit #(
                .DATA_WIDTH(DATA_WIDTH),
                .SATURATE  (SATURATE)
            ) u_lane (
                .a   (data_in[i*DATA_WIDTH +: DATA_WIDTH]),
                .b   (operand[i*DATA_WIDTH +: DATA_WIDTH]),
                .op  (op[i*OP_WIDTH +: OP_WIDTH]),
                .y   (lane_res[i*DATA_WIDTH +: DATA_WIDTH]),
                .flag(lane_flag[i])
            );
        end
    endgenerate
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    assign in_hs    = in_valid && in_ready;
    always_comb begin
        s1_sum = '0;
        for (int l = 0; l < NUM_LANES; l++)
            s1_sum = s1_sum + SUM_W'(s1_res[l*DATA_WIDTH +: DATA_WIDTH]);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_res   <= '0;
            s1_flags <= '0;
        end else if (in_hs) begin
            s1_valid <= 1'b1;
            s1_res   <= lane_res;
            s1_flags <= lane_flag;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end
    // Stage 2 data only moves with a real beat, so bubbles and stalls leave outputs untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
            sum_out   <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result  <= s1_res;
                flags   <= s1_flags;
                sum_out <= s1_sum;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            beat_count <= '0;
        else if (out_valid && out_ready)
            beat_count <= beat_count + 1'b1;
    end
endmodule
